// File: rtl/cordic_polar_to_rect_if.sv
// Bundles the request, result and flag signals of the polar-to-rectangular CORDIC.
// Handshake: start is taken on a rising edge where busy=0, and mag/angle are sampled
// on that same edge. start while busy=1 is dropped. done is a one-cycle pulse, and
// Zout and the flags are valid from that cycle on, held until the next done.
interface cordic_polar_to_rect_if;
   logic        start;
   logic [15:0] mag;
   logic [15:0] angle;
   logic        busy;
   logic        done;
   logic [31:0] Zout;
   logic        OR;
   logic        OI;
   logic        NR;
   logic        NI;
   logic        ZR;
   logic        ZI;
   logic        dbgState;

   modport master (
      output start, mag, angle,
      input  busy, done, Zout, OR, OI, NR, NI, ZR, ZI, dbgState
   );

   modport slave (
      input  start, mag, angle,
      output busy, done, Zout, OR, OI, NR, NI, ZR, ZI, dbgState
   );
endinterface

// File: rtl/cordic_polar_to_rect.sv
// Iterative rotation-mode CORDIC: (magnitude, phase) -> packed {real, imag}.
// One micro-rotation per clock. Only one operation is in flight at a time.
module cordic_polar_to_rect #(
   parameter int ITER = 14
) (
   input logic                   clk,
   input logic                   rst,
   cordic_polar_to_rect_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, ROT = 1'b1} state_t;

   localparam logic [3:0] LAST = 4'(ITER - 1);

   state_t             state, stateNext;
   logic               busyInt, accept, lastRot;
   logic [31:0]        prod;
   logic [16:0]        mComp;
   logic signed [17:0] mPos;
   logic signed [17:0] xLoad, yLoad;
   logic signed [15:0] zLoad;
   logic signed [17:0] x, y, xNext, yNext, xShift, yShift;
   logic signed [15:0] z, zNext, atanVal;
   logic [3:0]         cnt;
   logic signed [15:0] xSat, ySat;
   logic               xOvf, yOvf;
   logic [31:0]        zoutR;
   logic               orR, oiR, nrR, niR, zrR, ziR, doneR;

   // Clamp an 18-bit lane to the signed 16-bit output range.
   function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
      if (v > 18'sd32767)       return 16'sh7FFF;
      else if (v < -18'sd32768) return 16'sh8000;
      else                      return v[15:0];
   endfunction

   // 1/K gain pre-compensation in Q1.15. The result fits in 16 bits (at most 39797).
   assign prod  = 32'(bus.mag) * 32'd19899;
   assign mComp = 17'(prod >> 15);
   assign mPos  = signed'({1'b0, mComp});

   // Quadrant pre-rotation: fold the phase into [-pi/2, pi/2) before the micro-rotations.
   always_comb begin
      xLoad = '0;
      yLoad = '0;
      zLoad = bus.angle;
      case (bus.angle[15:14])
         2'b01: begin
            yLoad = mPos;
            zLoad = bus.angle - 16'h4000;
         end
         2'b10: begin
            yLoad = -mPos;
            zLoad = bus.angle + 16'h4000;
         end
         default: xLoad = mPos;
      endcase
   end

   // atan(2^-i) ROM, with pi = 0x8000 angle units.
   always_comb begin
      atanVal = '0;
      case (cnt)
         4'd0:    atanVal = 16'sd8192;
         4'd1:    atanVal = 16'sd4836;
         4'd2:    atanVal = 16'sd2555;
         4'd3:    atanVal = 16'sd1297;
         4'd4:    atanVal = 16'sd651;
         4'd5:    atanVal = 16'sd326;
         4'd6:    atanVal = 16'sd163;
         4'd7:    atanVal = 16'sd81;
         4'd8:    atanVal = 16'sd41;
         4'd9:    atanVal = 16'sd20;
         4'd10:   atanVal = 16'sd10;
         4'd11:   atanVal = 16'sd5;
         4'd12:   atanVal = 16'sd3;
         4'd13:   atanVal = 16'sd1;
         default: atanVal = '0;
      endcase
   end

   // One micro-rotation. Both lanes use the pre-update x and y.
   always_comb begin
      xShift = x >>> cnt;
      yShift = y >>> cnt;
      xNext  = x;
      yNext  = y;
      zNext  = z;
      if (!z[15]) begin
         xNext = x - yShift;
         yNext = y + xShift;
         zNext = z - atanVal;
      end else begin
         xNext = x + yShift;
         yNext = y - xShift;
         zNext = z + atanVal;
      end
   end

   // The final rotation's result goes straight into the output stage, so clamp xNext/yNext.
   assign xSat = sat16(xNext);
   assign ySat = sat16(yNext);
   assign xOvf = (xNext > 18'sd32767) || (xNext < -18'sd32768);
   assign yOvf = (yNext > 18'sd32767) || (yNext < -18'sd32768);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // FSM next state and control decode.
   always_comb begin
      stateNext = state;
      busyInt   = 1'b0;
      accept    = 1'b0;
      lastRot   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               stateNext = ROT;
            end
         end
         ROT: begin
            busyInt = 1'b1;
            if (cnt == LAST) begin
               lastRot   = 1'b1;
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Rotation datapath: load on accept, rotate once per ROT cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         x   <= '0;
         y   <= '0;
         z   <= '0;
         cnt <= '0;
      end else if (accept) begin
         x   <= xLoad;
         y   <= yLoad;
         z   <= zLoad;
         cnt <= '0;
      end else if (state == ROT) begin
         x   <= xNext;
         y   <= yNext;
         z   <= zNext;
         cnt <= cnt + 4'd1;
      end
   end

   // Output stage: capture the result and flags on the last rotation, pulse done.
   always_ff @(posedge clk) begin
      if (rst) begin
         doneR <= 1'b0;
         zoutR <= '0;
         orR   <= 1'b0;
         oiR   <= 1'b0;
         nrR   <= 1'b0;
         niR   <= 1'b0;
         zrR   <= 1'b0;
         ziR   <= 1'b0;
      end else begin
         doneR <= lastRot;
         if (lastRot) begin
            zoutR <= {xSat, ySat};
            orR   <= xOvf;
            oiR   <= yOvf;
            nrR   <= xSat[15];
            niR   <= ySat[15];
            zrR   <= (xSat == 16'sd0);
            ziR   <= (ySat == 16'sd0);
         end
      end
   end

   assign bus.busy     = busyInt;
   assign bus.done     = doneR;
   assign bus.Zout     = zoutR;
   assign bus.OR       = orR;
   assign bus.OI       = oiR;
   assign bus.NR       = nrR;
   assign bus.NI       = niR;
   assign bus.ZR       = zrR;
   assign bus.ZI       = ziR;
   assign bus.dbgState = state;

endmodule

// File: tb/tb_cordic_polar_to_rect.sv
// Bench for cordic_polar_to_rect: a real-valued polar model feeds a scoreboard,
// plus handshake timing, ignored-start and mid-operation reset scenarios.
`timescale 1ns/1ps
module tb_cordic_polar_to_rect;
   localparam int  ITER = 14;
   localparam real PI   = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   n;

   logic [31:0] expQ[$];
   logic [31:0] tolQ[$];
   logic [11:0] flagQ[$];
   string       flagNames[6] = '{"ZI", "ZR", "NI", "NR", "OI", "OR"};

   cordic_polar_to_rect_if bus ();

   cordic_polar_to_rect #(.ITER(ITER)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic checkVal(input string tag, input int obs, input int exp, input int tol = 0);
      checks++;
      if (obs < exp - tol || obs > exp + tol) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (+-%0d)", tag, obs, exp, tol);
      end
   endtask

   // Per-lane model. Flags are only checked where the tolerance band cannot flip them.
   function automatic void compModel(input real fv, input int tIn, output int e, output int t,
                                     output logic [2:0] msk, output logic [2:0] val);
      t   = tIn;
      msk = '0;
      val = '0;
      if (fv > 32767.0 + tIn) begin
         e = 32767; t = 0; msk[2] = 1'b1; val[2] = 1'b1;
      end else if (fv < -32768.0 - tIn) begin
         e = -32768; t = 0; msk[2] = 1'b1; val[2] = 1'b1;
      end else begin
         e = int'(fv);
         if (e > 32767)  e = 32767;
         if (e < -32768) e = -32768;
         if (fv <= 32767.0 - tIn && fv >= -32768.0 + tIn) msk[2] = 1'b1;
      end
      if (fv > tIn) msk[1] = 1'b1;
      else if (fv < -tIn) begin
         msk[1] = 1'b1; val[1] = 1'b1;
      end else if (tIn == 0) begin
         msk[1] = 1'b1; val[1] = (e < 0);
      end
      if (fv > tIn || fv < -tIn) msk[0] = 1'b1;
      else if (tIn == 0) begin
         msk[0] = 1'b1; val[0] = (e == 0);
      end
   endfunction

   task automatic pushExp(input logic [15:0] m, input logic [15:0] a);
      real        th, fr, fi;
      int         er, ei, tr, ti, tolBase;
      logic [2:0] mr, vr, mi, vi;
      th      = real'($signed(a)) * PI / 32768.0;
      fr      = real'(m) * $cos(th);
      fi      = real'(m) * $sin(th);
      tolBase = (m == 16'd0) ? 0 : ((m > 16'd32767) ? 16 : 8);
      compModel(fr, tolBase, er, tr, mr, vr);
      compModel(fi, tolBase, ei, ti, mi, vi);
      expQ.push_back({er[15:0], ei[15:0]});
      tolQ.push_back({tr[15:0], ti[15:0]});
      flagQ.push_back({mr[2], mi[2], mr[1], mi[1], mr[0], mi[0],
                       vr[2], vi[2], vr[1], vi[1], vr[0], vi[0]});
   endtask

   // Driver: present a request for one edge. The expectation is queued when track=1.
   task automatic startOp(input logic [15:0] m, input logic [15:0] a, input bit track);
      bus.start = 1'b1;
      bus.mag   = m;
      bus.angle = a;
      if (track) pushExp(m, a);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Count negedges after the accept edge until done, bounded.
   task automatic waitDone(output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!bus.done && cnt < 40);
   endtask

   // Scoreboard: compare every done against the oldest queued expectation.
   always @(negedge clk) begin
      logic [31:0] e, t;
      logic [11:0] f;
      logic [5:0]  obsF;
      if (bus.done) begin
         checkVal("pending_at_done", int'(expQ.size() > 0), 1);
         if (expQ.size() > 0) begin
            e    = expQ.pop_front();
            t    = tolQ.pop_front();
            f    = flagQ.pop_front();
            obsF = {bus.OR, bus.OI, bus.NR, bus.NI, bus.ZR, bus.ZI};
            checkVal("real", int'($signed(bus.Zout[31:16])), int'($signed(e[31:16])), int'(t[31:16]));
            checkVal("imag", int'($signed(bus.Zout[15:0])), int'($signed(e[15:0])), int'(t[15:0]));
            for (int i = 0; i < 6; i++)
               if (f[6 + i]) checkVal(flagNames[i], int'(obsF[i]), int'(f[i]));
         end
      end
   end

   logic [15:0] tblMag[8]   = '{16'd10000, 16'd10000, 16'd10000, 16'd10000,
                                16'hFFFF, 16'd0, 16'd0, 16'd32767};
   logic [15:0] tblAngle[8] = '{16'h2000, 16'h8000, 16'h6000, 16'h4000,
                                16'h0000, 16'h1234, 16'hC000, 16'hC000};

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.mag   = '0;
      bus.angle = '0;
      repeat (3) @(negedge clk);
      checkVal("rst_busy", int'(bus.busy), 0);
      checkVal("rst_done", int'(bus.done), 0);
      checkVal("rst_zout", int'(bus.Zout), 0);
      checkVal("rst_flags", int'({bus.OR, bus.OI, bus.NR, bus.NI, bus.ZR, bus.ZI}), 0);
      rst = 1'b0;
      @(negedge clk);

      // Basic operation, with handshake timing.
      startOp(16'd10000, 16'h0000, 1'b1);
      @(negedge clk);
      n = 1;
      checkVal("busy_cycle1", int'(bus.busy), 1);
      while (!bus.done && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkVal("latency", n, ITER + 1);
      checkVal("busy_in_done", int'(bus.busy), 0);
      @(negedge clk);
      checkVal("done_one_cycle", int'(bus.done), 0);

      // Stimulus table, back to back, with a restart in each done cycle.
      for (int i = 0; i < 8; i++) begin
         startOp(tblMag[i], tblAngle[i], 1'b1);
         waitDone(n);
         checkVal("tbl_latency", n, ITER + 1);
      end

      // Random back-to-back operations.
      for (int i = 0; i < 8; i++) begin
         startOp(16'($urandom_range(1000, 16000)), 16'($urandom_range(0, 65535)), 1'b1);
         waitDone(n);
         checkVal("rnd_latency", n, ITER + 1);
      end

      // Start pulses in cycles 3..10 must be ignored.
      @(negedge clk);
      startOp(16'd12345, 16'h1234, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n >= 3 && n <= 10) begin
            bus.start = 1'b1;
            bus.mag   = 16'($urandom_range(0, 65535));
            bus.angle = 16'($urandom_range(0, 65535));
         end else begin
            bus.start = 1'b0;
         end
      end while (!bus.done && n < 40);
      bus.start = 1'b0;
      checkVal("ignored_latency", n, ITER + 1);
      repeat (20) @(negedge clk);

      // Reset in cycle 5 aborts the operation with no done.
      startOp(16'd20000, 16'h3000, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkVal("abort_busy", int'(bus.busy), 0);
      checkVal("abort_zout", int'(bus.Zout), 0);
      checkVal("abort_flags", int'({bus.OR, bus.OI, bus.NR, bus.NI, bus.ZR, bus.ZI}), 0);
      rst = 1'b0;
      repeat (25) @(negedge clk);

      checkVal("queue_empty", expQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
